// File: rtl/check_if.sv
// Stim/check datapath channels: check FIFO, result FIFO, log FIFO and command port.
interface check_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int STF_WIDTH  = 24,
  parameter int ORV_WIDTH  = 8,
  parameter int CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24
);
  logic [CHF_WIDTH-1:0]          cfifo_data;
  logic                          cfifo_rdreq;
  logic                          cfifo_rdempty;
  logic [STF_WIDTH-1:0]          rfifo_data;
  logic                          rfifo_rdreq;
  logic                          rfifo_rdempty;
  logic [ADDR_WIDTH+STF_WIDTH:0] log_data;
  logic                          log_wrreq;
  logic                          log_wrfull;
  logic [SCC_WIDTH-1:0]          sc_cmd;
  logic [SCD_WIDTH-1:0]          sc_data;
  logic                          sc_ready;

  modport master (
    input  cfifo_data, cfifo_rdempty, rfifo_data, rfifo_rdempty, log_wrfull, sc_cmd, sc_data,
    output cfifo_rdreq, rfifo_rdreq, log_data, log_wrreq, sc_ready
  );

  modport slave (
    output cfifo_data, cfifo_rdempty, rfifo_data, rfifo_rdempty, log_wrfull, sc_cmd, sc_data,
    input  cfifo_rdreq, rfifo_rdreq, log_data, log_wrreq, sc_ready
  );
endinterface

// File: rtl/check.sv
// Compares captured DUT results against expected words under a bitmask,
// counts pass/fail and logs mismatches (or every vector when LOG_PASS=1).
//
// state   | meaning
// IDLE    | accept commands, wait for both FIFOs non-empty and log not full
// READ    | pop one word from check and result FIFOs
// LATCH   | register expected, address and actual
// COMPARE | evaluate masked mismatch, bump pass/fail counter
// WRITE   | push {fail, address, actual} to the log FIFO
module check #(
  parameter int ADDR_WIDTH = 20,
  parameter int STF_WIDTH  = 24,
  parameter int ORV_WIDTH  = 8,
  parameter int CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16,
  parameter int LOG_PASS   = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  check_if.master              bus,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] pass_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic                 any_fail
);
  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK = SCC_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, READ, LATCH, COMPARE, WRITE} state_t;

  state_t                state, state_nxt;
  logic [STF_WIDTH-1:0]  mask;
  logic [STF_WIDTH-1:0]  exp_q;
  logic [STF_WIDTH-1:0]  act_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  fail_q;
  logic                  mask_load;
  logic                  start;
  logic                  fail_now;
  logic                  unused_bits;

  assign mask_load = (state == IDLE) && (bus.sc_cmd == CMD_BITMASK);
  // A command accepted this cycle defers the vector fetch by one cycle.
  assign start     = !bus.cfifo_rdempty && !bus.rfifo_rdempty && !bus.log_wrfull && !mask_load;
  assign fail_now  = |((act_q ^ exp_q) & mask);
  assign bus.log_data = {fail_q, addr_q, act_q};
  assign unused_bits  = ^{bus.cfifo_data[ORV_WIDTH-1:0], bus.sc_data};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.cfifo_rdreq = 1'b0;
    bus.rfifo_rdreq = 1'b0;
    bus.log_wrreq   = 1'b0;
    bus.sc_ready    = 1'b0;
    case (state)
      IDLE: begin
        bus.sc_ready = 1'b1;
        if (start) state_nxt = READ;
      end
      READ: begin
        bus.cfifo_rdreq = 1'b1;
        bus.rfifo_rdreq = 1'b1;
        state_nxt       = LATCH;
      end
      LATCH:   state_nxt = COMPARE;
      COMPARE: state_nxt = (fail_now || (LOG_PASS != 0)) ? WRITE : IDLE;
      WRITE: begin
        bus.log_wrreq = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '1;
      exp_q  <= '0;
      act_q  <= '0;
      addr_q <= '0;
      fail_q <= 1'b0;
    end else begin
      if (mask_load) mask <= bus.sc_data[STF_WIDTH-1:0];
      if (state == LATCH) begin
        exp_q  <= bus.cfifo_data[CHF_WIDTH-1 -: STF_WIDTH];
        addr_q <= bus.cfifo_data[CHF_WIDTH-STF_WIDTH-1 -: ADDR_WIDTH];
        act_q  <= bus.rfifo_data;
      end
      if (state == COMPARE) fail_q <= fail_now;
    end
  end

  // Clear wins over a concurrent increment; counters stick at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      any_fail <= 1'b0;
    end else if (cnt_clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      any_fail <= 1'b0;
    end else if (state == COMPARE) begin
      if (fail_now) begin
        any_fail <= 1'b1;
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
      end else if (pass_cnt != '1) begin
        pass_cnt <= pass_cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_check.sv
// Bench for check: FIFO models, log scoreboard, vector table and corner sequences.
module tb_check;
  localparam int AW   = 20;
  localparam int SW   = 24;
  localparam int OW   = 8;
  localparam int CW   = SW + OW + AW;
  localparam int CNTW = 4;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            cnt_clear = 1'b0;
  logic [CNTW-1:0] pass_cnt, fail_cnt;
  logic            any_fail;

  check_if #(.ADDR_WIDTH(AW), .STF_WIDTH(SW), .ORV_WIDTH(OW)) bus();

  check #(.ADDR_WIDTH(AW), .STF_WIDTH(SW), .ORV_WIDTH(OW), .CNT_WIDTH(CNTW), .LOG_PASS(0)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .cnt_clear(cnt_clear),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .any_fail(any_fail)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [SW-1:0] mask;
    logic [SW-1:0] expv;
    logic [SW-1:0] act;
    logic [AW-1:0] addr;
    logic [OW-1:0] orv;
    logic          fail;
  } vec_t;

  vec_t          tbl[7];
  logic [CW-1:0] cq[$];
  logic [SW-1:0] rq[$];
  logic [AW+SW:0] lq[$];

  int   n_cmp = 0, n_bad = 0, cyc = 0, last_rd = 0;
  int   m_pass = 0, m_fail = 0;
  logic m_any = 1'b0;
  logic s_crd, s_rrd, s_ready, prev_rd = 1'b0, hold_r = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    s_crd   = bus.cfifo_rdreq;
    s_rrd   = bus.rfifo_rdreq;
    s_ready = bus.sc_ready;
    if (s_crd || s_rrd) begin
      chk("rdreq_pair", s_rrd, s_crd);
      chk("rdreq_single_cycle", prev_rd, 1'b0);
      last_rd = cyc;
    end
    prev_rd = s_crd;
    if (bus.log_wrreq) begin
      if (lq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_log actual=%0h required=no_write (cycle %0d)", bus.log_data, cyc);
      end else begin
        chk("log_data", bus.log_data, lq.pop_front());
        chk("log_latency", cyc - last_rd, 3);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (s_crd && cq.size() > 0) bus.cfifo_data = cq.pop_front();
    if (s_rrd && rq.size() > 0) bus.rfifo_data = rq.pop_front();
    bus.cfifo_rdempty = (cq.size() == 0);
    bus.rfifo_rdempty = (rq.size() == 0) || hold_r;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_vec(input logic [SW-1:0] expv, input logic [AW-1:0] addr,
                          input logic [SW-1:0] act, input logic [OW-1:0] orv,
                          input logic fail, input bit counted);
    cq.push_back({expv, addr, orv});
    rq.push_back(act);
    bus.cfifo_rdempty = 1'b0;
    bus.rfifo_rdempty = hold_r;
    if (counted) begin
      if (fail) begin
        if (m_fail < (1 << CNTW) - 1) m_fail++;
        m_any = 1'b1;
        lq.push_back({1'b1, addr, act});
      end else if (m_pass < (1 << CNTW) - 1) begin
        m_pass++;
      end
    end
  endtask

  task automatic set_mask(input logic [SW-1:0] m);
    bus.sc_cmd  = 5'b00001;
    bus.sc_data = m;
    tick();
    chk("sc_ready_cmd", s_ready, 1'b1);
    bus.sc_cmd = 5'b00000;
  endtask

  task automatic wait_rd(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = s_crd;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s actual=no_rdreq required=rdreq_within_10", nm);
    end
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_pass_cnt"}, pass_cnt, m_pass);
    chk({nm, "_fail_cnt"}, fail_cnt, m_fail);
    chk({nm, "_any_fail"}, any_fail, m_any);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{24'hFFFFFF, 24'h00A5A5, 24'h00A5A5, 20'h00010, 8'h00, 1'b0};
    tbl[1] = '{24'hFFFFFF, 24'h00A5A5, 24'h00A5A4, 20'h00011, 8'h3C, 1'b1};
    tbl[2] = '{24'hFFFFFE, 24'h00A5A5, 24'h00A5A4, 20'h00011, 8'h00, 1'b0};
    tbl[3] = '{24'h000000, 24'hFFFFFF, 24'h000000, 20'h00020, 8'hFF, 1'b0};
    tbl[4] = '{24'h800000, 24'h123456, 24'h923456, 20'h00030, 8'h00, 1'b1};
    tbl[5] = '{24'h0F0F0F, 24'hABCDEF, 24'h5B3D1F, 20'h00040, 8'h5A, 1'b0};
    tbl[6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 20'hFFFFF, 8'h00, 1'b0};

    bus.cfifo_data = '0; bus.rfifo_data = '0;
    bus.cfifo_rdempty = 1'b1; bus.rfifo_rdempty = 1'b1;
    bus.log_wrfull = 1'b0; bus.sc_cmd = '0; bus.sc_data = '0;

    #12;
    chk("rst_cfifo_rdreq", bus.cfifo_rdreq, 1'b0);
    chk("rst_log_wrreq", bus.log_wrreq, 1'b0);
    chk("rst_log_data", bus.log_data, '0);
    chk_counts("rst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    chk("sc_ready_after_release", s_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      set_mask(tbl[i].mask);
      push_vec(tbl[i].expv, tbl[i].addr, tbl[i].act, tbl[i].orv, tbl[i].fail, 1'b1);
      settle(7);
      chk_counts($sformatf("vec%0d", i));
    end

    // BITMASK accepted in the same cycle the FIFOs turn non-empty
    push_vec(24'h00A5A5, 20'h00012, 24'h00A5A4, 8'h00, 1'b0, 1'b1);
    bus.sc_cmd = 5'b00001; bus.sc_data = 24'hFFFFFE;
    tick();
    chk("defer_rd_c0", s_crd, 1'b0);
    chk("defer_ready_c0", s_ready, 1'b1);
    bus.sc_cmd = 5'b00000;
    tick();
    chk("defer_rd_c1", s_crd, 1'b0);
    tick();
    chk("defer_rd_c2", s_crd, 1'b1);
    settle(6);
    chk_counts("defer");

    // log full holds the vector in IDLE
    set_mask(24'hFFFFFF);
    bus.log_wrfull = 1'b1;
    push_vec(24'h000F00, 20'h00050, 24'h000F01, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrfull_no_rd", s_crd, 1'b0);
    end
    bus.log_wrfull = 1'b0;
    wait_rd("wrfull_release");
    settle(6);
    chk_counts("wrfull");

    // only one FIFO non-empty
    hold_r = 1'b1;
    push_vec(24'h000001, 20'h00060, 24'h000001, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("one_empty_no_rd", s_crd, 1'b0);
    end
    hold_r = 1'b0;
    wait_rd("one_empty_release");
    settle(6);
    chk_counts("one_empty");

    // cnt_clear coincides with COMPARE of a failing vector
    push_vec(24'h0000AA, 20'h00070, 24'h000055, 8'h00, 1'b1, 1'b1);
    wait_rd("clear_rd");
    tick();
    cnt_clear = 1'b1;
    m_pass = 0; m_fail = 0; m_any = 1'b0;
    tick();
    cnt_clear = 1'b0;
    settle(5);
    chk_counts("clear_in_compare");

    // reset during LATCH abandons the vector
    push_vec(24'h00A5A5, 20'h00099, 24'h000000, 8'h00, 1'b1, 1'b0);
    wait_rd("rst_rd");
    reset_n = 1'b0;
    m_pass = 0; m_fail = 0; m_any = 1'b0;
    #2;
    chk("midrst_cfifo_rdreq", bus.cfifo_rdreq, 1'b0);
    chk("midrst_rfifo_rdreq", bus.rfifo_rdreq, 1'b0);
    chk("midrst_log_wrreq", bus.log_wrreq, 1'b0);
    chk("midrst_log_data", bus.log_data, '0);
    chk_counts("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_sc_ready", s_ready, 1'b1);
    settle(8);
    chk_counts("midrst_after");

    // null and unknown commands leave the mask alone
    bus.sc_cmd = 5'b00000; bus.sc_data = 24'h000000;
    tick();
    bus.sc_cmd = 5'b00010;
    tick();
    bus.sc_cmd = 5'b00000;
    push_vec(24'h000001, 20'h000A0, 24'h000000, 8'h00, 1'b1, 1'b1);
    settle(7);
    chk_counts("ignored_cmd");

    // fail counter saturation
    for (int i = 0; i < 16; i++) begin
      push_vec(24'h000000, 20'h00100 + AW'(i), SW'(i + 1), 8'h00, 1'b1, 1'b1);
      settle(7);
    end
    chk("fail_cnt_saturated", fail_cnt, 4'hF);
    chk_counts("saturate");

    chk("log_queue_drained", lq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
